// File: rtl/base_aburp_pipe_if.sv
// rtl/base_aburp_pipe_if.sv - valid/ready stream bundle for base_aburp_pipe (producer side, consumer side, flush, occupancy)
interface base_aburp_pipe_if #(
  parameter int dw = 1,
  parameter int cw = 2
);
  logic          i_v;
  logic [0:dw-1] i_d;
  logic          i_r;
  logic          o_v;
  logic [0:dw-1] o_d;
  logic          o_r;
  logic          i_flush;
  logic [cw-1:0] o_cnt;

  // environment view: drives producer data, consumer ready and flush
  modport master (
    output i_v, i_d, o_r, i_flush,
    input  i_r, o_v, o_d, o_cnt
  );

  // pipe view
  modport slave (
    input  i_v, i_d, o_r, i_flush,
    output i_r, o_v, o_d, o_cnt
  );
endinterface

// File: rtl/base_aburp_pipe.sv
// rtl/base_aburp_pipe.sv - fully registered elastic pipeline stage of configurable depth; optional flush via BASE_ABURP_PIPE_FLUSH_EN
module base_aburp_pipe #(
  parameter int width     = 1,
  parameter int del_width = 0,
  parameter int depth     = 2
) (
  input  logic            clk,
  input  logic            reset,
  base_aburp_pipe_if.slave bus
);
  localparam int dw = width + del_width;
  localparam int cw = $clog2(depth + 1);
  localparam int pw = $clog2(depth);

  logic [0:dw-1] mem [depth];
  logic [pw-1:0] rd_ptr, wr_ptr, rd_ptr_inc, wr_ptr_inc;
  logic [cw-1:0] cnt, cnt_next;
  logic          accept, deliver, flush;
  logic          head_load;
  logic [0:dw-1] head_next;

  // i_r and o_v are flops, so both handshakes are decided purely from registered state
  assign accept  = bus.i_v & bus.i_r;
  assign deliver = bus.o_v & bus.o_r;
  assign bus.o_cnt = cnt;

`ifdef BASE_ABURP_PIPE_FLUSH_EN
  assign flush = bus.i_flush;
`else
  assign flush = 1'b0;
`endif

  // pointer wrap (depth need not be a power of two), next occupancy and next head value
  always_comb begin
    rd_ptr_inc = (rd_ptr == pw'(depth - 1)) ? '0 : rd_ptr + pw'(1);
    wr_ptr_inc = (wr_ptr == pw'(depth - 1)) ? '0 : wr_ptr + pw'(1);
    cnt_next   = cnt + cw'(accept) - cw'(deliver);
    head_load  = 1'b0;
    head_next  = bus.o_d;
    if (cnt == '0 && accept) begin
      // empty: incoming beat becomes the head
      head_load = 1'b1;
      head_next = bus.i_d;
    end else if (deliver && cnt > cw'(1)) begin
      // the entry behind the head is already stored
      head_load = 1'b1;
      head_next = mem[rd_ptr_inc];
    end else if (deliver && accept) begin
      // single entry replaced by the beat arriving on the same edge
      head_load = 1'b1;
      head_next = bus.i_d;
    end
  end

  // storage array; no reset needed, entries are only visible through the head register
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= bus.i_d;
  end

  // pointers, occupancy and registered handshake/head outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      cnt     <= '0;
      bus.i_r <= 1'b1;
      bus.o_v <= 1'b0;
      bus.o_d <= '0;
    end else if (flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      cnt     <= '0;
      bus.i_r <= 1'b1;
      bus.o_v <= 1'b0;
    end else begin
      if (accept)  wr_ptr <= wr_ptr_inc;
      if (deliver) rd_ptr <= rd_ptr_inc;
      cnt     <= cnt_next;
      bus.o_v <= (cnt_next != '0);
      bus.i_r <= (cnt_next < cw'(depth));
      if (head_load) bus.o_d <= head_next;
    end
  end
endmodule
